skid_buffer: RTL and testbench
==============================

# skid_buffer

Two-entry elastic buffer on a valid/ready stream, placed directly upstream of a `Register`/`Prev` stage. It breaks the combinational `out_ready` → `in_ready` path so the downstream stage can be a plain enabled register. Both handshake outputs are registered, and it sustains one transfer per cycle. Downstream logic uses `out_valid & out_ready` as the `write_en` of the consuming register.

## Interface
- `WIDTH`, default 32: data width in bits.
- `SAFE`, default 0: data reset value; 0 resets data registers to `'x`, nonzero resets them to `'0`.

- `clk`, input, 1: clock.
- `reset`, input, 1: reset; synchronous, active-high.
- `in_valid`, input, 1: upstream has data.
- `in_ready`, output, 1: buffer accepts data.
- `in_data`, input, WIDTH: upstream data.
- `out_valid`, output, 1: buffer presents data.
- `out_ready`, input, 1: downstream consumes data.
- `out_data`, output, WIDTH: head-of-buffer data.
- `count`, output, 2: occupancy, 0..2.

## Operation
- `in_fire = in_valid & in_ready`.
- `out_fire = out_valid & out_ready`.
- Storage:
  - `main` register drives `out_data`.
  - `skid` register holds the overflow entry.
- States: EMPTY (count 0), BUSY (count 1), FULL (count 2).
- EMPTY:
  - `in_fire` → BUSY, `main <= in_data`.
  - Otherwise stay.
- BUSY:
  - `in_fire & !out_fire` → FULL, `skid <= in_data`.
  - `!in_fire & out_fire` → EMPTY.
  - `in_fire & out_fire` → BUSY, `main <= in_data`.
  - Neither → stay; `main` holds.
- FULL:
  - `in_ready` = 0, so `in_fire` cannot occur.
  - `out_fire` → BUSY, `main <= skid`.
  - Otherwise stay; both registers hold.
- Output decode:
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL).
  - `count` = state encoding.
  - All are decoded from state only.
- `in_data` is ignored when `in_fire` = 0.
- `out_data` is don't-care when `out_valid` = 0.
- Ordering: strict FIFO, no loss, no duplication.
- `in_valid` asserted while `in_ready` = 0 is legal. Upstream must hold data; the buffer does not sample it.

## Timing
- Reset:
  - State → EMPTY, so `out_valid` = 0, `in_ready` = 1 and `count` = 0 from the first cycle after reset.
  - `main` and `skid` → `'x` (SAFE=0) or `'0` (SAFE≠0).
- While `reset` is high:
  - All handshakes are ignored; no transfer is counted.
  - Reset mid-operation discards all held entries.
- Latency: data accepted at edge N appears on `out_data` with `out_valid` = 1 in cycle N+1.
- Throughput: 1 item/cycle steady state with `out_ready` held high. State stays BUSY.
- Combinational paths:
  - None input→output.
  - `in_ready` does not depend on `out_ready` in the same cycle.
  - `out_valid` does not depend on `in_valid` in the same cycle.
- Stall recovery: FULL with `out_ready` rising drains `main` at that edge and `skid` one cycle later. `in_ready` returns to 1 one cycle after the first drain.

## Structure
- Shared package `skid_pkg`:
  - `typedef enum logic [1:0] {EMPTY=2'd0, BUSY=2'd1, FULL=2'd2} skid_state_t`.
  - 2'd3 is illegal. The FSM forces it to EMPTY and flags it with an assertion.
- Sub-module `skid_buffer_ctrl`:
  - Owns the FSM, `in_ready`/`out_valid`/`count`.
  - Produces `main_en`, `main_sel` (0 = `in_data`, 1 = `skid`) and `skid_en`.
- Data storage: two `Prev` primitives, `WIDTH` and `SAFE` passed through, `write_en` from the controller.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset` 2 cycles, then `in_valid` = 0.
  - Required: `out_valid` = 0, `in_ready` = 1, `count` = 0. With SAFE=1, `out_data` = 0.
- Single pass:
  - Stimulus: `in_valid` = 1, `in_data` = 0xA5 for one cycle; `out_ready` = 1.
  - Required: 0xA5 on `out_data` with `out_valid` one cycle later; then EMPTY.
- Streaming:
  - Stimulus: 0,1,…,15 on consecutive cycles, `out_ready` = 1.
  - Required: output 0..15 on consecutive cycles, 1-cycle offset, `count` = 1 throughout.
- Backpressure:
  - Stimulus: `out_ready` = 0, push 0x11, 0x22, 0x33.
  - Required:
    - 0x11 and 0x22 accepted; `count` = 2; `in_ready` = 0; 0x33 held by upstream.
    - Raise `out_ready`: output order is 0x11, 0x22, 0x33.
- Simultaneous fire in BUSY:
  - Stimulus: `main` = 0x01, push 0x02 with `out_ready` = 1.
  - Required: 0x01 consumed, `main` = 0x02, state BUSY, `count` = 1.
- Reset while FULL:
  - Stimulus: assert `reset` one cycle.
  - Required: next cycle `count` = 0, `out_valid` = 0, `in_ready` = 1; held entries never appear.

Source files
------------

// File: rtl/skid_pkg.sv
// Shared types for the two-entry skid buffer.
package skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/prev.sv
// Enabled register primitive with selectable reset value.
module Prev #(
    parameter int WIDTH = 32,
    parameter int SAFE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= (SAFE != 0) ? '0 : 'x;
        end else if (write_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_buffer_ctrl.sv
// Occupancy FSM for the skid buffer; all handshake outputs decode from state only.
module skid_buffer_ctrl
    import skid_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        out_ready,
    output logic        in_ready,
    output logic        out_valid,
    output logic [1:0]  count,
    output logic        main_en,
    output logic        main_sel,
    output logic        skid_en,
    output skid_state_t state_dbg
);

    // Handshake: a transfer happens on a rising clk edge when valid and ready
    // are both high; valid must hold with stable data until ready is seen.
    skid_state_t state, state_next;
    logic        in_fire, out_fire;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign count     = state;
    assign state_dbg = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        main_en    = 1'b0;
        main_sel   = 1'b0;
        skid_en    = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next = BUSY;
                    main_en    = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && !out_fire) begin
                    state_next = FULL;
                    skid_en    = 1'b1;
                end else if (!in_fire && out_fire) begin
                    state_next = EMPTY;
                end else if (in_fire && out_fire) begin
                    main_en    = 1'b1;
                end
            end
            FULL: begin
                // Overflow entry moves up as the head leaves.
                if (out_fire) begin
                    state_next = BUSY;
                    main_en    = 1'b1;
                    main_sel   = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    illegal_state_a: assert property (@(posedge clk) disable iff (reset)
        state != skid_state_t'(2'd3));

endmodule

// File: rtl/skid_buffer.sv
// Two-entry elastic buffer that registers both in_ready and out_valid.
module skid_buffer
    import skid_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SAFE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic             main_en, main_sel, skid_en;
    logic [WIDTH-1:0] skid_q, main_d;
    skid_state_t      state_dbg;

    skid_buffer_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .count     (count),
        .main_en   (main_en),
        .main_sel  (main_sel),
        .skid_en   (skid_en),
        .state_dbg (state_dbg)
    );

    assign main_d = main_sel ? skid_q : in_data;

    Prev #(.WIDTH(WIDTH), .SAFE(SAFE)) u_main (
        .clk      (clk),
        .reset    (reset),
        .write_en (main_en),
        .d        (main_d),
        .q        (out_data)
    );

    Prev #(.WIDTH(WIDTH), .SAFE(SAFE)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .write_en (skid_en),
        .d        (in_data),
        .q        (skid_q)
    );

endmodule

// File: tb/tb_skid_buffer.sv
// Directed bench for skid_buffer with SAFE=1 and an 8-bit data path.
module tb_skid_buffer;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    skid_buffer #(.WIDTH(W), .SAFE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic ov, input logic ir, input logic [1:0] c);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, "_in_ready"},  32'(in_ready),  32'(ir));
        check({tag, "_count"},     32'(count),     32'(c));
    endtask

    initial begin
        logic [W-1:0] exp_v;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset then idle
        check_status("reset", 1'b0, 1'b1, 2'd0);
        check("reset_data", 32'(out_data), 32'h0);
        tick();
        check_status("idle", 1'b0, 1'b1, 2'd0);

        // Single pass
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = $urandom_range(0, 255);
        check_status("single", 1'b1, 1'b1, 2'd1);
        check("single_data", 32'(out_data), 32'hA5);
        tick();
        check_status("single_drain", 1'b0, 1'b1, 2'd0);

        // Streaming 0..15, one item per cycle
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            exp_q.push_back(W'(i));
            tick();
            exp_v = exp_q.pop_front();
            check("stream_data", 32'(out_data), 32'(exp_v));
            check_status("stream", 1'b1, 1'b1, 2'd1);
        end
        in_valid = 1'b0;
        tick();
        check_status("stream_end", 1'b0, 1'b1, 2'd0);

        // Backpressure: two accepted, third held upstream
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        check_status("bp_one", 1'b1, 1'b1, 2'd1);
        in_data = 8'h22;
        tick();
        check_status("bp_full", 1'b1, 1'b0, 2'd2);
        check("bp_head", 32'(out_data), 32'h11);
        in_data = 8'h33;
        tick();
        check_status("bp_hold", 1'b1, 1'b0, 2'd2);
        check("bp_hold_head", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        tick();
        check_status("bp_drain1", 1'b1, 1'b1, 2'd1);
        check("bp_drain1_data", 32'(out_data), 32'h22);
        tick();
        in_valid = 1'b0;
        check_status("bp_drain2", 1'b1, 1'b1, 2'd1);
        check("bp_drain2_data", 32'(out_data), 32'h33);
        tick();
        check_status("bp_empty", 1'b0, 1'b1, 2'd0);

        // Simultaneous fire in BUSY
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01;
        tick();
        check("sim_first", 32'(out_data), 32'h01);
        in_data = 8'h02; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_status("sim_busy", 1'b1, 1'b1, 2'd1);
        check("sim_data", 32'(out_data), 32'h02);
        tick();
        check_status("sim_empty", 1'b0, 1'b1, 2'd0);

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hAA;
        tick();
        in_data = 8'hBB;
        tick();
        check_status("rf_full", 1'b1, 1'b0, 2'd2);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        reset = 1'b0;
        check_status("rf_reset", 1'b0, 1'b1, 2'd0);
        check("rf_data", 32'(out_data), 32'h0);
        tick();
        check_status("rf_after", 1'b0, 1'b1, 2'd0);
        tick();
        check_status("rf_after2", 1'b0, 1'b1, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
